dl11_fifo_regs: RTL and testbench

- Next-generation DL11 console/serial register block for the pdp11 iopage.
- Parametrised base address, vector pair, character width and FIFO depth.
- Adds receive and transmit FIFOs, an overrun flag and edge-qualified bus access.
- Sits between the iopage bus and the existing uart core, driving the core's ld_tx_data/uld_rx_data handshake. Multiple instances give extra DL11 lines.

---
 rtl/dl11_fifo_regs.sv | 221 ++++++++++++++++++++++
 tb/tb_dl11_fifo_regs.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl11_fifo_regs.sv
// DL11 serial register block with RX/TX FIFOs, overrun flag and edge-qualified bus access.
// Optional loopback (XCSR MAINT) is compiled in with DL11_LOOPBACK_EN.

module dl11_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       push_ok
);
  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          pop_ok;

  assign empty   = (cnt == '0);
  assign full    = cnt[AW];
  assign pop_ok  = pop && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end
endmodule

module dl11_fifo_regs #(
  parameter logic [12:0] BASE_ADDR = 13'o17560,
  parameter logic [7:0]  VECTOR    = 8'o60,
  parameter int          FIFO_AW   = 4,
  parameter int          DATA_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] iopage_addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        decode,
  input  logic        iopage_rd,
  input  logic        iopage_wr,
  input  logic        iopage_byte_op,
  output logic        interrupt,
  output logic [7:0]  vector,
  output logic        ld_tx_data,
  output logic [7:0]  tx_data,
  input  logic        tx_empty,
  output logic        uld_rx_data,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty
);
  localparam logic [7:0] CMASK = (DATA_BITS == 7) ? 8'h7f : 8'hff;

  typedef enum logic [1:0] {RX_IDLE, RX_CAPT, RX_PUSH} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_BUSY} tx_state_t;

  rx_state_t   rx_st, rx_nxt;
  tx_state_t   tx_st, tx_nxt;
  logic [12:0] off;
  logic [1:0]  sel;
  logic        rd_q, wr_q, rd_evt, wr_evt;
  logic        rx_ie, tx_ie, ovr, maint;
  logic [7:0]  rx_latch, xbuf_last;
  logic        rx_push_uart, lb_push, tx_pop, rbuf_pop;
  logic        rxf_push, rxf_push_ok, rxf_empty, rxf_full;
  logic [7:0]  rxf_din, rxf_head;
  logic        txf_push, txf_push_ok, txf_empty, txf_full;
  logic [7:0]  txf_head;
  logic        rx_int, tx_int;
  logic        unused_ok;

  assign off    = iopage_addr - BASE_ADDR;
  assign decode = (off[12:3] == '0);
  assign sel    = off[2:1];
  assign rd_evt = iopage_rd && decode && !rd_q;
  // odd-byte writes are decoded but have no effect
  assign wr_evt = iopage_wr && decode && !wr_q && !(iopage_byte_op && iopage_addr[0]);

  assign rbuf_pop = rd_evt && (sel == 2'd1) && !rxf_empty;
  assign txf_push = wr_evt && (sel == 2'd3);
  assign rxf_push = rx_push_uart || lb_push;
  assign rxf_din  = rx_push_uart ? (rx_latch & CMASK) : txf_head;

  dl11_fifo #(.AW(FIFO_AW)) u_rxf (
    .clk(clk), .reset(reset), .push(rxf_push), .din(rxf_din), .pop(rbuf_pop),
    .head(rxf_head), .empty(rxf_empty), .full(rxf_full), .push_ok(rxf_push_ok)
  );

  dl11_fifo #(.AW(FIFO_AW)) u_txf (
    .clk(clk), .reset(reset), .push(txf_push), .din(data_in[7:0] & CMASK), .pop(tx_pop),
    .head(txf_head), .empty(txf_empty), .full(txf_full), .push_ok(txf_push_ok)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rx_ie     <= 1'b0;
      tx_ie     <= 1'b0;
      ovr       <= 1'b0;
      xbuf_last <= '0;
      rx_latch  <= '0;
      rx_st     <= RX_IDLE;
      tx_st     <= TX_IDLE;
    end else begin
      rd_q  <= iopage_rd;
      wr_q  <= iopage_wr;
      rx_st <= rx_nxt;
      tx_st <= tx_nxt;
      if (rx_st == RX_CAPT) rx_latch <= rx_data;
      if (wr_evt && sel == 2'd0) rx_ie <= data_in[6];
      if (wr_evt && sel == 2'd2) tx_ie <= data_in[6];
      if (txf_push) xbuf_last <= data_in[7:0] & CMASK;
      // a dropped character wins over a simultaneous clear
      if (rxf_push && !rxf_push_ok) ovr <= 1'b1;
      else if (rbuf_pop)            ovr <= 1'b0;
    end
  end

`ifdef DL11_LOOPBACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     maint <= 1'b0;
    else if (wr_evt && sel == 2'd2) maint <= data_in[2];
  end
`else
  assign maint = 1'b0;
`endif

  always_comb begin
    rx_nxt       = rx_st;
    uld_rx_data  = 1'b0;
    rx_push_uart = 1'b0;
    case (rx_st)
      RX_IDLE: if (!rx_empty) rx_nxt = RX_CAPT;
      RX_CAPT: begin
        uld_rx_data = 1'b1;
        if (rx_empty) rx_nxt = RX_PUSH;
      end
      RX_PUSH: begin
        rx_push_uart = 1'b1;
        rx_nxt       = RX_IDLE;
      end
      default: rx_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_nxt     = tx_st;
    ld_tx_data = 1'b0;
    tx_pop     = 1'b0;
    lb_push    = 1'b0;
    case (tx_st)
      TX_IDLE: if (!txf_empty) tx_nxt = TX_LOAD;
      TX_LOAD: begin
`ifdef DL11_LOOPBACK_EN
        // loopback: IDLE->LOAD->pop gives one char per 2 clks; uart RX push has priority
        if (maint) begin
          if (!rx_push_uart) begin
            lb_push = 1'b1;
            tx_pop  = 1'b1;
            tx_nxt  = TX_IDLE;
          end
        end else begin
          ld_tx_data = 1'b1;
          if (!tx_empty) begin
            tx_pop = 1'b1;
            tx_nxt = TX_BUSY;
          end
        end
`else
        ld_tx_data = 1'b1;
        if (!tx_empty) begin
          tx_pop = 1'b1;
          tx_nxt = TX_BUSY;
        end
`endif
      end
      TX_BUSY: if (tx_empty) tx_nxt = TX_IDLE;
      default: tx_nxt = TX_IDLE;
    endcase
  end

  assign tx_data = txf_head;

  always_comb begin
    data_out = '0;
    if (iopage_rd && decode) begin
      case (sel)
        2'd0: data_out = {8'h00, !rxf_empty, rx_ie, 6'b0};
        2'd1: data_out = {ovr, ovr, 6'b0, rxf_empty ? 8'h00 : rxf_head};
        2'd2: data_out = {8'h00, !txf_full, tx_ie, 3'b0, maint, 2'b0};
        default: data_out = {8'h00, xbuf_last};
      endcase
    end
  end

  assign rx_int    = rx_ie && !rxf_empty;
  assign tx_int    = tx_ie && !txf_full;
  assign interrupt = rx_int || tx_int;
  assign vector    = rx_int ? VECTOR : (tx_int ? VECTOR + 8'd4 : 8'h00);

  assign unused_ok = ^{data_in[15:8], off[0], rxf_full, txf_push_ok};
endmodule

// File: tb/tb_dl11_fifo_regs.sv
// Bench for dl11_fifo_regs: a FIFO_AW=2 8-bit instance plus a 7-bit instance at another base,
// checked against a queue-based model of the RX path and expected TX character order.
module tb_dl11_fifo_regs;
  localparam logic [12:0] BASE  = 13'o17560;
  localparam logic [12:0] BASE7 = 13'o16500;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] iopage_addr;
  logic [15:0] data_in;
  logic        iopage_rd, iopage_wr, iopage_byte_op;
  logic        tx_empty, rx_empty;
  logic [7:0]  rx_data;

  logic [15:0] data_out, data_out7;
  logic        decode, decode7, interrupt, interrupt7;
  logic [7:0]  vector, vector7, tx_data, tx_data7;
  logic        ld_tx_data, ld_tx_data7, uld_rx_data, uld_rx_data7;

  int checks = 0;
  int errors = 0;
  byte unsigned rx_q[$];
  bit ovr_m;
  int ld_rises = 0;
  logic ld_prev = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ld_prev <= ld_tx_data;
    if (ld_tx_data && !ld_prev) ld_rises <= ld_rises + 1;
  end

  dl11_fifo_regs #(.BASE_ADDR(BASE), .VECTOR(8'o60), .FIFO_AW(2), .DATA_BITS(8)) u_dut (
    .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
    .data_out(data_out), .decode(decode), .iopage_rd(iopage_rd), .iopage_wr(iopage_wr),
    .iopage_byte_op(iopage_byte_op), .interrupt(interrupt), .vector(vector),
    .ld_tx_data(ld_tx_data), .tx_data(tx_data), .tx_empty(tx_empty),
    .uld_rx_data(uld_rx_data), .rx_data(rx_data), .rx_empty(rx_empty)
  );

  dl11_fifo_regs #(.BASE_ADDR(BASE7), .VECTOR(8'o60), .FIFO_AW(4), .DATA_BITS(7)) u_dut7 (
    .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
    .data_out(data_out7), .decode(decode7), .iopage_rd(iopage_rd), .iopage_wr(iopage_wr),
    .iopage_byte_op(iopage_byte_op), .interrupt(interrupt7), .vector(vector7),
    .ld_tx_data(ld_tx_data7), .tx_data(tx_data7), .tx_empty(tx_empty),
    .uld_rx_data(uld_rx_data7), .rx_data(rx_data), .rx_empty(rx_empty)
  );

  task automatic bus_read(input logic [12:0] a, input int hold, input bit use7, output logic [15:0] d);
    @(negedge clk);
    iopage_addr = a;
    iopage_rd   = 1'b1;
    #1 d = use7 ? data_out7 : data_out;
    repeat (hold) @(negedge clk);
    iopage_rd = 1'b0;
  endtask

  task automatic bus_write(input logic [12:0] a, input logic [15:0] d, input logic bop);
    @(negedge clk);
    iopage_addr    = a;
    data_in        = d;
    iopage_wr      = 1'b1;
    iopage_byte_op = bop;
    @(negedge clk);
    iopage_wr      = 1'b0;
    iopage_byte_op = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rx_q.delete();
    ovr_m = 1'b0;
  endtask

  // uart RX side: offer a char, wait for the unload strobe, then go empty
  task automatic inject(input byte unsigned c);
    int n;
    @(negedge clk);
    rx_data  = c;
    rx_empty = 1'b0;
    n = 0;
    while (uld_rx_data !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL inject_timeout: uld_rx_data never asserted for char %02h", c);
    end
    rx_empty = 1'b1;
    repeat (2) @(negedge clk);
    if (rx_q.size() < DEPTH) rx_q.push_back(c);
    else ovr_m = 1'b1;
  endtask

  function automatic logic [15:0] model_rbuf();
    logic [15:0] e;
    if (rx_q.size() > 0) begin
      e = {ovr_m, ovr_m, 6'b0, rx_q.pop_front()};
      ovr_m = 1'b0;
    end else begin
      e = {ovr_m, ovr_m, 14'b0};
    end
    return e;
  endfunction

  task automatic test_reset();
    logic [15:0] d;
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) bus_write(BASE + 13'd6, 16'h0030 + 16'(i), 1'b0);
    n = 0;
    while (ld_tx_data !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (ld_tx_data !== 1'b1) begin errors++; $display("FAIL reset_ld_wait: ld_tx_data=%b want 1", ld_tx_data); end
    tx_empty = 1'b0;
    @(negedge clk);
    checks++;
    if (ld_tx_data !== 1'b0) begin errors++; $display("FAIL busy_ld: ld_tx_data=%b want 0", ld_tx_data); end
    reset = 1'b0;
    #1;
    checks++;
    if ({ld_tx_data, uld_rx_data, interrupt, vector, data_out} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: ld=%b uld=%b int=%b vec=%o dout=%h want all 0",
               ld_tx_data, uld_rx_data, interrupt, vector, data_out);
    end
    tx_empty = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    rx_q.delete(); ovr_m = 1'b0;
    bus_read(BASE + 13'd4, 1, 1'b0, d);
    checks++;
    if (d !== 16'o000200) begin errors++; $display("FAIL reset_xcsr: got %o want 000200", d); end
    bus_read(BASE, 1, 1'b0, d);
    checks++;
    if (d !== 16'o000000) begin errors++; $display("FAIL reset_rcsr: got %o want 000000", d); end
    repeat (3) @(negedge clk);
    checks++;
    if (ld_tx_data !== 1'b0) begin errors++; $display("FAIL reset_tx_idle: ld_tx_data=%b want 0", ld_tx_data); end
  endtask

  task automatic test_tx_burst(input byte unsigned c0, input byte unsigned c1, input byte unsigned c2);
    byte unsigned exp[3];
    logic [15:0] d;
    int r0, n;
    exp[0] = c0; exp[1] = c1; exp[2] = c2;
    do_reset();
    r0 = ld_rises;
    for (int i = 0; i < 3; i++) bus_write(BASE + 13'd6, {8'h00, exp[i]}, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (ld_tx_data !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (tx_data !== exp[i] || ld_tx_data !== 1'b1) begin
        errors++;
        $display("FAIL tx_char%0d: ld=%b tx_data=%h want 1/%h", i, ld_tx_data, tx_data, exp[i]);
      end
      tx_empty = 1'b0;
      bus_read(BASE + 13'd4, 1, 1'b0, d);
      checks++;
      if (d[7] !== 1'b1) begin errors++; $display("FAIL tx_ready%0d: XCSR=%o want bit7 set", i, d); end
      repeat (8) @(negedge clk);
      tx_empty = 1'b1;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (ld_rises - r0 !== 3 || ld_tx_data !== 1'b0) begin
      errors++;
      $display("FAIL tx_pulses: pulses=%0d ld=%b want 3/0", ld_rises - r0, ld_tx_data);
    end
  endtask

  task automatic test_tx_full();
    byte unsigned exp[$];
    byte unsigned c;
    logic [15:0] d;
    int n;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      c = 8'($urandom);
      exp.push_back(c);
      bus_write(BASE + 13'd6, {8'h00, c}, 1'b0);
    end
    bus_read(BASE + 13'd4, 1, 1'b0, d);
    checks++;
    if (d !== 16'o000000) begin errors++; $display("FAIL tx_full_xcsr: got %o want 000000", d); end
    bus_write(BASE + 13'd6, 16'h00EE, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      n = 0;
      while (ld_tx_data !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (ld_tx_data !== 1'b1 || tx_data !== exp[i]) begin
        errors++;
        $display("FAIL tx_drain%0d: ld=%b tx_data=%h want 1/%h", i, ld_tx_data, tx_data, exp[i]);
      end
      tx_empty = 1'b0;
      repeat (2) @(negedge clk);
      tx_empty = 1'b1;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (ld_tx_data !== 1'b0) begin errors++; $display("FAIL tx_drop: ld=%b want 0 (dropped char sent)", ld_tx_data); end
  endtask

  task automatic test_rx_overrun();
    logic [15:0] d, e;
    do_reset();
    for (int i = 0; i < 5; i++) inject(8'($urandom));
    for (int i = 0; i < 5; i++) begin
      e = model_rbuf();
      bus_read(BASE + 13'd2, 1, 1'b0, d);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rx_overrun_rd%0d: got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_int_priority();
    logic [15:0] d, e;
    do_reset();
    #1;
    checks++;
    if (interrupt !== 1'b0 || vector !== 8'h00) begin
      errors++; $display("FAIL int_idle: int=%b vec=%o want 0/0", interrupt, vector);
    end
    bus_write(BASE, 16'o000100, 1'b0);
    bus_write(BASE + 13'd4, 16'o000100, 1'b0);
    #1;
    checks++;
    if (interrupt !== 1'b1 || vector !== 8'o64) begin
      errors++; $display("FAIL int_tx_only: int=%b vec=%o want 1/64", interrupt, vector);
    end
    inject(8'($urandom));
    #1;
    checks++;
    if (interrupt !== 1'b1 || vector !== 8'o60) begin
      errors++; $display("FAIL int_rx_prio: int=%b vec=%o want 1/60", interrupt, vector);
    end
    e = model_rbuf();
    bus_read(BASE + 13'd2, 1, 1'b0, d);
    checks++;
    if (d !== e) begin errors++; $display("FAIL int_rbuf: got %h want %h", d, e); end
    #1;
    checks++;
    if (interrupt !== 1'b1 || vector !== 8'o64) begin
      errors++; $display("FAIL int_after_read: int=%b vec=%o want 1/64", interrupt, vector);
    end
  endtask

  task automatic test_multi_strobe();
    logic [15:0] d, e;
    do_reset();
    inject(8'($urandom));
    inject(8'($urandom));
    e = model_rbuf();
    bus_read(BASE + 13'd2, 4, 1'b0, d);
    checks++;
    if (d !== e) begin errors++; $display("FAIL strobe_first: got %h want %h", d, e); end
    e = model_rbuf();
    bus_read(BASE + 13'd2, 1, 1'b0, d);
    checks++;
    if (d !== e) begin errors++; $display("FAIL strobe_second: got %h want %h", d, e); end
    bus_read(BASE, 1, 1'b0, d);
    checks++;
    if (d !== 16'o000000) begin errors++; $display("FAIL strobe_done: RCSR=%o want 000000", d); end
  endtask

  task automatic test_byte_write();
    logic [15:0] d;
    do_reset();
    bus_write(BASE + 13'd1, 16'h4040, 1'b1);
    bus_read(BASE, 1, 1'b0, d);
    checks++;
    if (d !== 16'o000000) begin errors++; $display("FAIL odd_byte: RCSR=%o want 000000", d); end
    bus_write(BASE, 16'h0040, 1'b1);
    bus_read(BASE, 1, 1'b0, d);
    checks++;
    if (d !== 16'o000100) begin errors++; $display("FAIL low_byte: RCSR=%o want 000100", d); end
    bus_write(BASE + 13'd6, 16'h125A, 1'b0);
    bus_read(BASE + 13'd6, 1, 1'b0, d);
    checks++;
    if (d !== 16'h005A) begin errors++; $display("FAIL xbuf_rd: got %h want 005a", d); end
    @(negedge clk);
    iopage_addr = BASE + 13'd8;
    #1;
    checks++;
    if (decode !== 1'b0 || data_out !== 16'h0) begin
      errors++; $display("FAIL decode_miss: decode=%b dout=%h want 0/0", decode, data_out);
    end
    iopage_addr = BASE + 13'd6;
    #1;
    checks++;
    if (decode !== 1'b1) begin errors++; $display("FAIL decode_hit: decode=%b want 1", decode); end
  endtask

  task automatic test_random_rx();
    logic [15:0] d, e;
    int op;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      if (op == 0) inject(8'($urandom));
      else if (op == 1) begin
        e = model_rbuf();
        bus_read(BASE + 13'd2, $urandom_range(1, 3), 1'b0, d);
        checks++;
        if (d !== e) begin errors++; $display("FAIL rand_rbuf%0d: got %h want %h", i, d, e); end
      end else begin
        e = {8'h00, rx_q.size() > 0, 7'b0};
        bus_read(BASE, 1, 1'b0, d);
        checks++;
        if (d !== e) begin errors++; $display("FAIL rand_rcsr%0d: got %h want %h", i, d, e); end
      end
    end
  endtask

  task automatic test_data_bits7();
    logic [15:0] d;
    do_reset();
    inject(8'hC1);
    bus_read(BASE7 + 13'd2, 1, 1'b1, d);
    checks++;
    if (d !== 16'o000101) begin errors++; $display("FAIL bits7_rx: got %o want 000101", d); end
    bus_write(BASE7 + 13'd6, 16'h00FF, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (ld_tx_data7 !== 1'b1 || tx_data7 !== 8'h7F) begin
      errors++; $display("FAIL bits7_tx: ld=%b tx_data=%h want 1/7f", ld_tx_data7, tx_data7);
    end
  endtask

  initial begin
    reset = 1'b0;
    iopage_addr = '0; data_in = '0;
    iopage_rd = 1'b0; iopage_wr = 1'b0; iopage_byte_op = 1'b0;
    tx_empty = 1'b1; rx_empty = 1'b1; rx_data = '0;
    ovr_m = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_tx_burst(8'h41, 8'h42, 8'h43);
    test_tx_burst(8'($urandom), 8'($urandom), 8'($urandom));
    test_tx_full();
    test_rx_overrun();
    test_int_priority();
    test_multi_strobe();
    test_byte_write();
    test_random_rx();
    test_data_bits7();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
